// File: rtl/kbd_mem_defs.sv
// Shared definitions for the keyboard ring buffer: FSM encodings and the
// control-block word offsets also used by the CPU-side driver.
package kbd_mem_defs;

  typedef enum logic [2:0] {
    ST_INIT0   = 3'd0,
    ST_INIT1   = 3'd1,
    ST_IDLE    = 3'd2,
    ST_RD_TAIL = 3'd3,
    ST_CHECK   = 3'd4,
    ST_WR_DATA = 3'd5,
    ST_WR_HEAD = 3'd6
  } kbd_state_e;

  localparam int unsigned HEAD_OFS = 0;
  localparam int unsigned TAIL_OFS = 1;
  localparam int unsigned DATA_OFS = 2;

  localparam int unsigned KEY_W  = 8;
  localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/kbd_mem_writer.sv
// Keyboard scancode producer for a memory-mapped ring buffer on data-memory
// port B; the CPU consumes entries and advances the tail word.
module kbd_mem_writer
  import kbd_mem_defs::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0400,
  parameter int unsigned DEPTH     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_valid,
  input  logic [KEY_W-1:0]  key_data,
  output logic              key_ready,
  output logic [WORD_W-1:0] io_addr,
  output logic              io_wren,
  output logic [WORD_W-1:0] io_wdata,
  input  logic [WORD_W-1:0] io_rdata,
  output logic [7:0]        drop_cnt,
  output logic [KEY_W-1:0]  last_key
);

  localparam int unsigned AW = $clog2(DEPTH);

  kbd_state_e state, state_nxt;

  logic [AW-1:0]    head;
  logic [AW-1:0]    head_nxt_c;
  logic [AW-1:0]    tail_c;
  logic             full_c;
  logic [KEY_W-1:0] key_r;
  logic             unused_rdata;

  // Only the low AW bits of the tail word are meaningful.
  assign tail_c       = io_rdata[AW-1:0];
  assign unused_rdata = ^io_rdata[WORD_W-1:AW];
  assign head_nxt_c   = head + AW'(1);
  assign full_c       = (head_nxt_c == tail_c);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_INIT0;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT0:   state_nxt = ST_INIT1;
      ST_INIT1:   state_nxt = ST_IDLE;
      ST_IDLE:    if (key_valid) state_nxt = ST_RD_TAIL;
      ST_RD_TAIL: state_nxt = ST_CHECK;
      ST_CHECK:   state_nxt = full_c ? ST_IDLE : ST_WR_DATA;
      ST_WR_DATA: state_nxt = ST_WR_HEAD;
      ST_WR_HEAD: state_nxt = ST_IDLE;
      default:    state_nxt = ST_INIT0;
    endcase
  end

  // Key latch, drop counter (saturating) and head pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      head     <= '0;
      drop_cnt <= '0;
      last_key <= '0;
      key_r    <= '0;
    end else begin
      if (state == ST_IDLE && key_valid) begin
        key_r    <= key_data;
        last_key <= key_data;
      end
      if (state == ST_CHECK && full_c && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
      if (state == ST_WR_HEAD)
        head <= head_nxt_c;
    end
  end

  always_comb begin
    key_ready = 1'b0;
    io_addr   = BASE_ADDR + 32'(HEAD_OFS);
    io_wren   = 1'b0;
    io_wdata  = '0;
    case (state)
      ST_INIT0: io_wren = 1'b1;
      ST_INIT1: begin
        io_addr = BASE_ADDR + 32'(TAIL_OFS);
        io_wren = 1'b1;
      end
      ST_IDLE:    key_ready = 1'b1;
      ST_RD_TAIL: io_addr = BASE_ADDR + 32'(TAIL_OFS);
      ST_WR_DATA: begin
        io_addr  = BASE_ADDR + 32'(DATA_OFS) + 32'(head);
        io_wren  = 1'b1;
        io_wdata = 32'(key_r);
      end
      ST_WR_HEAD: begin
        io_wren  = 1'b1;
        io_wdata = 32'(head_nxt_c);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_kbd_mem_writer.sv
// Self-checking bench for kbd_mem_writer: a port-B memory stub, a write
// monitor and a queue-free ring model driven by randomized scancodes.
module tb_kbd_mem_writer;

  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int          DEPTH = 16;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        key_valid = 1'b0;
  logic [7:0]  key_data = 8'h00;
  logic        key_ready;
  logic [31:0] io_addr;
  logic        io_wren;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata = 32'h0;
  logic [7:0]  drop_cnt;
  logic [7:0]  last_key;

  logic [31:0] tail_word = 32'h0;
  int          cyc = 0;
  int          wdata_leak = 0;
  wr_t         wr_q[$];

  int          errors = 0;
  int          checks = 0;

  int          m_head = 0;
  int          m_tail = 0;
  int          m_drop = 0;
  logic [7:0]  m_last = 8'h00;

  kbd_mem_writer #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_data(key_data),
    .key_ready(key_ready), .io_addr(io_addr), .io_wren(io_wren),
    .io_wdata(io_wdata), .io_rdata(io_rdata), .drop_cnt(drop_cnt),
    .last_key(last_key)
  );

  always #5 clk = ~clk;

  // Port-B stub: logs writes, returns the CPU tail word with one cycle latency.
  always @(posedge clk) begin
    if (io_wren) wr_q.push_back(wr_t'{cyc, io_addr, io_wdata});
    if (!io_wren && io_wdata !== 32'h0) wdata_leak <= wdata_leak + 1;
    io_rdata <= (io_addr == BASE + 32'd1) ? tail_word : 32'hDEAD_BEEF;
    cyc <= cyc + 1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  // CPU moves the tail; upper bits are junk the block must ignore.
  task automatic set_tail(input int t);
    m_tail    = t;
    tail_word = {28'($urandom()), 4'(t)};
  endtask

  task automatic model_reset();
    m_head = 0;
    m_drop = 0;
    m_last = 8'h00;
  endtask

  // Ring semantics: one slot kept free, drops saturate at 255.
  task automatic model_key(input logic [7:0] k, output bit wr,
                           output logic [31:0] da, output logic [31:0] dd,
                           output logic [31:0] ha, output logic [31:0] hd);
    m_last = k;
    da = 0; dd = 0; ha = 0; hd = 0;
    if (((m_head + 1) % DEPTH) == m_tail) begin
      wr = 1'b0;
      if (m_drop < 255) m_drop++;
    end else begin
      wr = 1'b1;
      da = BASE + 32'd2 + 32'(m_head);
      dd = {24'h0, k};
      m_head = (m_head + 1) % DEPTH;
      ha = BASE;
      hd = 32'(m_head);
    end
  endtask

  task automatic offer_key(input logic [7:0] k, output int t, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    key_valid = 1'b1;
    key_data  = k;
    for (int i = 0; i < 20; i++) begin
      if (key_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    t = cyc;
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    key_data  = 8'($urandom());
  endtask

  task automatic wait_ready(output int n);
    n = 99;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (key_ready) begin n = i; break; end
    end
  endtask

  task automatic test_reset();
    int t0, i0;
    rst = 1'b1;
    key_valid = 1'b0;
    set_tail(0);
    repeat (3) @(negedge clk);
    checks++;
    if (key_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_held: got %b want 0", key_ready);
    end
    rst = 1'b0;
    t0 = cyc;
    i0 = wr_q.size();
    model_reset();
    checks++;
    if (key_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_init0: got %b want 0", key_ready);
    end
    @(negedge clk);
    checks++;
    if (key_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_init1: got %b want 0", key_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (key_ready !== 1'b1) begin
        errors++; $display("FAIL reset_ready_idle%0d: got %b want 1", i, key_ready);
      end
    end
    checks++;
    if (wr_q.size() - i0 != 2) begin
      errors++; $display("FAIL reset_write_count: got %0d want 2", wr_q.size() - i0);
    end else begin
      checks++;
      if (wr_q[i0].addr !== BASE || wr_q[i0].data !== 32'h0 || wr_q[i0].cyc != t0) begin
        errors++;
        $display("FAIL reset_wr_head: got addr=%h data=%h cyc=%0d want addr=%h data=0 cyc=%0d",
                 wr_q[i0].addr, wr_q[i0].data, wr_q[i0].cyc, BASE, t0);
      end
      checks++;
      if (wr_q[i0+1].addr !== BASE + 32'd1 || wr_q[i0+1].data !== 32'h0 || wr_q[i0+1].cyc != t0 + 1) begin
        errors++;
        $display("FAIL reset_wr_tail: got addr=%h data=%h cyc=%0d want addr=%h data=0 cyc=%0d",
                 wr_q[i0+1].addr, wr_q[i0+1].data, wr_q[i0+1].cyc, BASE + 32'd1, t0 + 1);
      end
    end
    checks++;
    if (drop_cnt !== 8'h00 || last_key !== 8'h00) begin
      errors++; $display("FAIL reset_regs: got drop=%0d last=%h want drop=0 last=00", drop_cnt, last_key);
    end
  endtask

  task automatic test_single();
    int t, i0, n;
    bit ok, wr;
    logic [31:0] da, dd, ha, hd;
    set_tail(0);
    i0 = wr_q.size();
    offer_key(8'h1C, t, ok);
    wait_ready(n);
    model_key(8'h1C, wr, da, dd, ha, hd);
    checks++;
    if (!ok) begin errors++; $display("FAIL single_accept: key never accepted"); end
    checks++;
    if (n != 5) begin errors++; $display("FAIL single_ready_latency: got %0d want 5", n); end
    checks++;
    if (wr_q.size() - i0 != 2) begin
      errors++; $display("FAIL single_write_count: got %0d want 2", wr_q.size() - i0);
    end else begin
      checks++;
      if (wr_q[i0].addr !== BASE + 32'd2 || wr_q[i0].data !== 32'h1C || wr_q[i0].cyc != t + 3) begin
        errors++;
        $display("FAIL single_data_wr: got addr=%h data=%h cyc=%0d want addr=%h data=1c cyc=%0d",
                 wr_q[i0].addr, wr_q[i0].data, wr_q[i0].cyc, BASE + 32'd2, t + 3);
      end
      checks++;
      if (wr_q[i0+1].addr !== BASE || wr_q[i0+1].data !== 32'h1 || wr_q[i0+1].cyc != t + 4) begin
        errors++;
        $display("FAIL single_head_wr: got addr=%h data=%h cyc=%0d want addr=%h data=1 cyc=%0d",
                 wr_q[i0+1].addr, wr_q[i0+1].data, wr_q[i0+1].cyc, BASE, t + 4);
      end
    end
    checks++;
    if (last_key !== 8'h1C) begin errors++; $display("FAIL single_last_key: got %h want 1c", last_key); end
  endtask

  // Random keys: per-key latency, write log and status registers vs. model.
  task automatic run_keys(input string tag, input int count, input bit move_tail);
    int t, i0, n;
    bit ok, wr;
    logic [7:0] k;
    logic [31:0] da, dd, ha, hd;
    for (int j = 0; j < count; j++) begin
      if (move_tail) set_tail(int'($urandom_range(0, DEPTH - 1)));
      k = 8'($urandom());
      i0 = wr_q.size();
      offer_key(k, t, ok);
      wait_ready(n);
      model_key(k, wr, da, dd, ha, hd);
      checks++;
      if (!ok || n != (wr ? 5 : 3)) begin
        errors++; $display("FAIL %s_latency[%0d]: got ok=%0b n=%0d want n=%0d", tag, j, ok, n, wr ? 5 : 3);
      end
      checks++;
      if (wr_q.size() - i0 != (wr ? 2 : 0)) begin
        errors++; $display("FAIL %s_write_count[%0d]: got %0d want %0d", tag, j, wr_q.size() - i0, wr ? 2 : 0);
      end else if (wr) begin
        checks++;
        if (wr_q[i0].addr !== da || wr_q[i0].data !== dd || wr_q[i0].cyc != t + 3 ||
            wr_q[i0+1].addr !== ha || wr_q[i0+1].data !== hd || wr_q[i0+1].cyc != t + 4) begin
          errors++;
          $display("FAIL %s_writes[%0d]: got %h=%h@%0d %h=%h@%0d want %h=%h@%0d %h=%h@%0d", tag, j,
                   wr_q[i0].addr, wr_q[i0].data, wr_q[i0].cyc, wr_q[i0+1].addr, wr_q[i0+1].data,
                   wr_q[i0+1].cyc, da, dd, t + 3, ha, hd, t + 4);
        end
      end
      checks++;
      if (drop_cnt !== 8'(m_drop) || last_key !== m_last) begin
        errors++; $display("FAIL %s_status[%0d]: got drop=%0d last=%h want drop=%0d last=%h",
                           tag, j, drop_cnt, last_key, m_drop, m_last);
      end
    end
  endtask

  task automatic test_fill();
    set_tail(0);
    run_keys("fill", 14, 1'b0);
    checks++;
    if (m_head != 15) begin errors++; $display("FAIL fill_head_model: got %0d want 15", m_head); end
    run_keys("full", 1, 1'b0);
    checks++;
    if (drop_cnt !== 8'd1) begin errors++; $display("FAIL full_drop_cnt: got %0d want 1", drop_cnt); end
  endtask

  task automatic test_wrap();
    int i0;
    set_tail(5);
    i0 = wr_q.size();
    run_keys("wrap", 1, 1'b0);
    checks++;
    if (wr_q.size() - i0 != 2 || wr_q[i0].addr !== BASE + 32'd17 || wr_q[i0+1].data !== 32'h0) begin
      errors++; $display("FAIL wrap_target: got %0d writes want data at %h and head 0", wr_q.size() - i0, BASE + 32'd17);
    end
    run_keys("random", 40, 1'b1);
  endtask

  task automatic test_saturation();
    set_tail((m_head + 1) % DEPTH);
    run_keys("sat", 300, 1'b0);
    checks++;
    if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_drop_cnt: got %0d want 255", drop_cnt); end
  endtask

  task automatic test_reset_mid();
    int t, i0, n;
    bit ok;
    logic [7:0] k;
    set_tail(m_head);
    k = 8'($urandom());
    i0 = wr_q.size();
    offer_key(k, t, ok);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (!ok || wr_q.size() - i0 != 3) begin
      errors++; $display("FAIL rstmid_write_count: got ok=%0b count=%0d want 3", ok, wr_q.size() - i0);
    end else begin
      checks++;
      if (wr_q[i0].addr !== BASE + 32'd2 + 32'(m_head) || wr_q[i0].data !== {24'h0, k} || wr_q[i0].cyc != t + 3) begin
        errors++; $display("FAIL rstmid_data_wr: got %h=%h@%0d want %h=%h@%0d", wr_q[i0].addr,
                           wr_q[i0].data, wr_q[i0].cyc, BASE + 32'd2 + 32'(m_head), {24'h0, k}, t + 3);
      end
      checks++;
      if (wr_q[i0+1].addr !== BASE || wr_q[i0+1].data !== 32'h0 || wr_q[i0+1].cyc != t + 4 ||
          wr_q[i0+2].addr !== BASE + 32'd1 || wr_q[i0+2].data !== 32'h0 || wr_q[i0+2].cyc != t + 5) begin
        errors++; $display("FAIL rstmid_init_wr: got %h=%h@%0d %h=%h@%0d want init writes at %0d,%0d",
                           wr_q[i0+1].addr, wr_q[i0+1].data, wr_q[i0+1].cyc, wr_q[i0+2].addr,
                           wr_q[i0+2].data, wr_q[i0+2].cyc, t + 4, t + 5);
      end
    end
    model_reset();
    checks++;
    if (key_ready !== 1'b1 || drop_cnt !== 8'h00 || last_key !== 8'h00) begin
      errors++; $display("FAIL rstmid_regs: got ready=%b drop=%0d last=%h want 1 0 00", key_ready, drop_cnt, last_key);
    end
    set_tail(0);
    run_keys("post_rst", 3, 1'b0);
    wait_ready(n);
    checks++;
    if (wdata_leak !== 0) begin errors++; $display("FAIL idle_wdata: got %0d nonzero idle cycles want 0", wdata_leak); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_wrap();
    test_saturation();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kbd_mem_writer.md
KBD_MEM_WRITER -- requirements
Module: kbd_mem_writer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0400, meaning the word address of the ring-buffer control block on data-memory port B.
REQ-002 SHALL have parameter DEPTH, default 16, meaning the number of ring entries (power of two, 2..256); AW = log2(DEPTH).
REQ-003 SHALL have port clk, input, 1, the single clock, same clock as the data-memory port B.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port key_valid, input, 1, meaning a keyboard scancode is offered.
REQ-006 SHALL have port key_data, input, 8, the scancode.
REQ-007 SHALL have port key_ready, output, 1, meaning the block accepts key_data this cycle.
REQ-008 SHALL have port io_addr, output, 32, the port-B word address.
REQ-009 SHALL have port io_wren, output, 1, the port-B write enable.
REQ-010 SHALL have port io_wdata, output, 32, the port-B write data.
REQ-011 SHALL have port io_rdata, input, 32, the port-B read data, valid one cycle after its address.
REQ-012 SHALL have port drop_cnt, output, 8, the count of scancodes dropped because the ring was full.
REQ-013 SHALL have port last_key, output, 8, the last accepted scancode, for 7-SEG debug.

Function
REQ-014 The memory map SHALL be: BASE_ADDR holds head (written only by this block), BASE_ADDR+1 holds tail (written only by the CPU), BASE_ADDR+2+i holds entry i, for i in 0..DEPTH-1.
REQ-015 The states SHALL be INIT0, INIT1, IDLE, RD_TAIL, CHECK, WR_DATA and WR_HEAD.
REQ-016 INIT0 SHALL write 0 to BASE_ADDR, then INIT1 SHALL write 0 to BASE_ADDR+1, then the state SHALL go to IDLE.
REQ-017 key_ready SHALL be 1 only in IDLE; a transfer occurs when key_valid and key_ready are both 1.
REQ-018 On a transfer in cycle t, key_data SHALL be latched, last_key SHALL update, and the state SHALL go to RD_TAIL.
REQ-019 In RD_TAIL (t+1) the block SHALL drive io_addr=BASE_ADDR+1 with io_wren=0.
REQ-020 In CHECK (t+2), tail SHALL be io_rdata[AW-1:0]; upper bits SHALL be ignored.
REQ-021 In CHECK, full SHALL be ((head+1) mod DEPTH)==tail.
REQ-022 If full, drop_cnt SHALL increment (saturating at 255), the key SHALL be discarded, no write SHALL occur, and the state SHALL go to IDLE at t+3.
REQ-023 If not full, WR_DATA (t+3) SHALL write {24'b0,key} to BASE_ADDR+2+head.
REQ-024 WR_HEAD (t+4) SHALL write head_next=(head+1) mod DEPTH, zero-extended, to BASE_ADDR; the internal head SHALL update at the end of WR_HEAD, and the state SHALL go to IDLE at t+5.
REQ-025 head SHALL wrap from DEPTH-1 to 0.
REQ-026 Usable capacity SHALL be DEPTH-1 entries.
REQ-027 io_wren SHALL be 1 only in INIT0, INIT1, WR_DATA and WR_HEAD.
REQ-028 In IDLE, CHECK and the init states not writing, io_addr SHALL hold BASE_ADDR.
REQ-029 io_wdata SHALL be 0 whenever io_wren is 0.
REQ-030 All outputs SHALL be decoded from registered state and data; there SHALL be no combinational path from key_valid to any output except none; key_ready depends on state only.
REQ-031 While not in IDLE, key_valid SHALL be ignored; the producer holds its data.

Reset
REQ-032 When rst is sampled 1, the next state SHALL be INIT0 from any state, head=0, drop_cnt=0 and last_key=0.
REQ-033 An in-flight key SHALL be discarded with no partial write after reset is sampled.
REQ-034 key_ready SHALL be 0 throughout the INIT states.

Structure
REQ-035 State encodings and the control-block offsets (HEAD_OFS=0, TAIL_OFS=1, DATA_OFS=2) SHALL live in a shared header/package kbd_mem_defs used by this block and by the CPU-side driver constants.
REQ-036 The block SHALL be a single module with no sub-module; the saturating counter is inline.

Verification
REQ-037 Reset then idle: after rst, exactly two writes SHALL occur (BASE=0, BASE+1=0), then key_ready SHALL be 1 from the third cycle onward.
REQ-038 Single key 8'h1C with tail=0: data write 0x1C SHALL go to BASE+2 at t+3, head write 1 SHALL go to BASE at t+4, and key_ready SHALL return at t+5.
REQ-039 Fill with 15 keys and tail=0: all SHALL be written; a 16th key SHALL produce no write, drop_cnt=1, and key_ready back at t+3.
REQ-040 Wrap: with head=15 preset via 15 keys and CPU tail=5, the next key SHALL go to BASE+2+15 and the head write SHALL be 0.
REQ-041 Saturation: 300 keys with tail frozen at full SHALL leave drop_cnt=255.
REQ-042 Reset mid-WR_DATA: no WR_HEAD write SHALL occur, the INIT writes SHALL follow, and head=0.
